// File: rtl/edge_pulse_pkg.sv
// Shared types and parameter limits for the edge pulse generator.
package edge_pulse_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   localparam int unsigned CHANNELS_MIN        = 1;
   localparam int unsigned CHANNELS_MAX        = 32;
   localparam int unsigned SYNC_STAGES_MIN     = 2;
   localparam int unsigned SYNC_STAGES_MAX     = 4;
   localparam int unsigned DEBOUNCE_CYCLES_MIN = 1;
   localparam int unsigned DEBOUNCE_CYCLES_MAX = 65535;
   localparam int unsigned PULSE_LEN_MIN       = 1;
   localparam int unsigned PULSE_LEN_MAX       = 255;
   localparam int unsigned RETRIGGER_MAX       = 1;

   // True when a level transition into new_level is selected by mode m.
   function automatic logic edge_match(input edge_mode_e m, input logic new_level);
      logic hit;
      case (m)
         EDGE_RISE: hit = new_level;
         EDGE_FALL: hit = ~new_level;
         EDGE_BOTH: hit = 1'b1;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One channel: synchroniser, debounce filter, edge detect, pulse stretcher, overrun flag.
module edge_pulse_chan
   import edge_pulse_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1,
   parameter int unsigned PULSE_LEN       = 1,
   parameter int unsigned RETRIGGER       = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trigger,
   input  logic [1:0] mode,
   input  logic       ovr_clr,
   output logic       pulse_out,
   output logic       level,
   output logic       overrun
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned PW = $clog2(PULSE_LEN + 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
   logic                   level_q, level_d;
   logic [PW-1:0]          pcnt_q, pcnt_d;
   logic                   pulse_q, pulse_d;
   logic                   ovr_q, ovr_d;
   logic                   s;
   logic                   evt;
   logic                   ovr_set;

   assign s = sync_q[SYNC_STAGES-1];

   // Shift the raw trigger into the synchroniser chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], trigger};
   end

   // Debounce: accept a level change once s has differed for DEBOUNCE_CYCLES cycles.
   always_comb begin
      deb_cnt_d = '0;
      level_d   = level_q;
      if (s != level_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            level_d = ~level_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   // Event detect and pulse down-counter; the final pulse cycle still counts as active.
   always_comb begin
      evt     = (level_d != level_q) && edge_match(edge_mode_e'(mode), level_d);
      pcnt_d  = pcnt_q;
      ovr_set = 1'b0;
      if (pcnt_q != '0) begin
         pcnt_d = pcnt_q - 1'b1;
      end
      if (evt) begin
         if ((pcnt_q == '0) || (RETRIGGER != 0)) begin
            pcnt_d = PULSE_LOAD;
         end else begin
            ovr_set = 1'b1;
         end
      end
      pulse_d = (pcnt_d != '0);
      ovr_d   = ovr_set | (ovr_q & ~ovr_clr);
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         deb_cnt_q <= '0;
         level_q   <= 1'b0;
         pcnt_q    <= '0;
         pulse_q   <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         deb_cnt_q <= deb_cnt_d;
         level_q   <= level_d;
         pcnt_q    <= pcnt_d;
         pulse_q   <= pulse_d;
         ovr_q     <= ovr_d;
      end
   end

   assign pulse_out = pulse_q;
   assign level     = level_q;
   assign overrun   = ovr_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-triggered pulse generator; one independent channel per trigger bit.
module edge_pulse_gen
   import edge_pulse_pkg::*;
#(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1,
   parameter int unsigned PULSE_LEN       = 1,
   parameter int unsigned RETRIGGER       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   trigger,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]   ovr_clr,
   output logic [CHANNELS-1:0]   pulse_out,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   overrun
);

   if ((CHANNELS < CHANNELS_MIN) || (CHANNELS > CHANNELS_MAX)) begin : g_bad_channels
      $error("edge_pulse_gen: CHANNELS out of range");
   end
   if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
      $error("edge_pulse_gen: SYNC_STAGES out of range");
   end
   if ((DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) || (DEBOUNCE_CYCLES > DEBOUNCE_CYCLES_MAX)) begin : g_bad_deb
      $error("edge_pulse_gen: DEBOUNCE_CYCLES out of range");
   end
   if ((PULSE_LEN < PULSE_LEN_MIN) || (PULSE_LEN > PULSE_LEN_MAX)) begin : g_bad_len
      $error("edge_pulse_gen: PULSE_LEN out of range");
   end
   if (RETRIGGER > RETRIGGER_MAX) begin : g_bad_retrig
      $error("edge_pulse_gen: RETRIGGER must be 0 or 1");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      edge_pulse_chan #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .PULSE_LEN      (PULSE_LEN),
         .RETRIGGER      (RETRIGGER)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .trigger  (trigger[i]),
         .mode     (mode[2*i +: 2]),
         .ovr_clr  (ovr_clr[i]),
         .pulse_out(pulse_out[i]),
         .level    (level[i]),
         .overrun  (overrun[i])
      );
   end

endmodule
